// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side stream controller.
package fifo_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 16;
   localparam int SKID_DEPTH    = 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOP
   } rd_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered skid buffer that catches words returning from the FIFO's read port.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [1:0]       occupancy_o
);

   logic [WIDTH-1:0] mem_q [SKID_DEPTH];
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   logic [1:0]       occupancy_q, occupancy_d;

   // One-bit pointers wrap naturally at the two-entry depth.
   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      occupancy_d = occupancy_q;
      if (push_i) begin
         tail_d = ~tail_q;
      end
      if (pop_i) begin
         head_d = ~head_q;
      end
      occupancy_d = occupancy_q + 2'(push_i) - 2'(pop_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q      <= 1'b0;
         tail_q      <= 1'b0;
         occupancy_q <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[tail_q] <= data_i;
         end
         head_q      <= head_d;
         tail_q      <= tail_d;
         occupancy_q <= occupancy_d;
      end
   end

   assign data_o      = mem_q[head_q];
   assign occupancy_o = occupancy_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for synchronous_fifo: issues reads, absorbs the one-cycle read
// latency in a skid buffer and presents the words as a valid/ready stream.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic               fifo_rd_enb,
   input  logic [WIDTH-1:0]   fifo_data_out,
   input  logic               fifo_empty,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [WIDTH-1:0]   m_data,
   output logic               busy,
   output logic [COUNT_W-1:0] word_count
);

   rd_state_e          state_q, state_d;
   logic               inflight_q;
   logic [COUNT_W-1:0] wordCount_q;
   logic [1:0]         occupancy;
   logic               pop;
   logic [2:0]         slotsClaimed;

   assign pop     = m_valid & m_ready;
   assign m_valid = (occupancy != 2'd0);

   // A read is only issued when its returning word is guaranteed a free slot.
   assign slotsClaimed = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, pop};
   assign fifo_rd_enb  = (state_q == RUN) & ~fifo_empty & (slotsClaimed < 3'd2);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!en) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (en) begin
               state_d = RUN;
            end else if (!inflight_q && occupancy == 2'd0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         inflight_q  <= 1'b0;
         wordCount_q <= '0;
      end else begin
         state_q     <= state_d;
         inflight_q  <= fifo_rd_enb;
         wordCount_q <= wordCount_q + COUNT_W'(pop);
      end
   end

   fifo_skid_buf #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .pop_i       (pop),
      .data_i      (fifo_data_out),
      .data_o      (m_data),
      .occupancy_o (occupancy)
   );

   assign busy       = (state_q != IDLE) | inflight_q | (occupancy != 2'd0);
   assign word_count = wordCount_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and every
// word pushed is expected to reach the sink exactly once, in order.
module tb_fifo_stream_reader;

   localparam int WIDTH   = 8;
   localparam int COUNT_W = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic               fifo_rd_enb;
   logic [WIDTH-1:0]   fifo_data_out = '0;
   logic               fifo_empty = 1'b1;
   logic               m_valid;
   logic               m_ready;
   logic [WIDTH-1:0]   m_data;
   logic               busy;
   logic [COUNT_W-1:0] word_count;

   logic [WIDTH-1:0] fifoQ[$];
   logic [WIDTH-1:0] expQ[$];
   int               checks = 0;
   int               errors = 0;
   int               rdCount = 0;
   int               expCount = 0;
   logic             holdValid = 1'b0;
   logic [WIDTH-1:0] holdData = '0;

   fifo_stream_reader #(
      .WIDTH   (WIDTH),
      .COUNT_W (COUNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .fifo_rd_enb   (fifo_rd_enb),
      .fifo_data_out (fifo_data_out),
      .fifo_empty    (fifo_empty),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .busy          (busy),
      .word_count    (word_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural FIFO: a read in one cycle presents its word during the next.
   always @(posedge clk) begin
      if (rst) begin
         fifoQ.delete();
         fifo_empty    <= 1'b1;
         fifo_data_out <= '0;
      end else if (fifo_rd_enb) begin
         rdCount++;
         checkOutput("read_while_empty", (fifoQ.size() == 0), 0);
         if (fifoQ.size() != 0) begin
            fifo_data_out <= fifoQ.pop_front();
            fifo_empty    <= (fifoQ.size() == 0);
         end
      end
   end

   // Monitor: every accepted word must be the oldest outstanding pushed word.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("word_count", word_count, expCount[COUNT_W-1:0]);
         if (holdValid && m_valid) begin
            checkOutput("hold_data", m_data, holdData);
         end
         if (m_valid && m_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("extra_word", expQ.size(), 1);
            end else begin
               checkOutput("m_data", m_data, expQ.pop_front());
            end
            expCount++;
         end
         holdValid = m_valid & ~m_ready;
         holdData  = m_data;
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic enV, input logic readyV);
      nextCycle();
      en      = enV;
      m_ready = readyV;
   endtask

   task automatic pushWord(input logic [WIDTH-1:0] v);
      fifoQ.push_back(v);
      expQ.push_back(v);
      fifo_empty = 1'b0;
   endtask

   task automatic doReset();
      nextCycle();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      expQ.delete();
      expCount = 0;
   endtask

   task automatic drain();
      int n = 0;
      applyStimulus(1'b1, 1'b1);
      while ((fifoQ.size() != 0 || expQ.size() != 0) && n < 300) begin
         nextCycle();
         n++;
      end
      checkOutput("drain_all_delivered", expQ.size(), 0);
      en = 1'b0;
      n  = 0;
      while (busy && n < 20) begin
         nextCycle();
         n++;
      end
      checkOutput("drain_idle", busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [WIDTH-1:0] vals[4];
      int rd0;
      int base;
      int n;
      int bad;

      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      rst = 1'b1;
      en = 1'b0;
      m_ready = 1'b0;
      @(negedge clk);
      checkOutput("reset_rd_enb", fifo_rd_enb, 0);
      checkOutput("reset_m_valid", m_valid, 0);
      checkOutput("reset_m_data", m_data, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_word_count", word_count, 0);
      nextCycle();
      rst = 1'b0;

      $display("[TB] back-to-back burst");
      for (int i = 0; i < 4; i++) pushWord(vals[i]);
      applyStimulus(1'b1, 1'b1);
      n = 0;
      while (!m_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t1_first_valid", m_valid, 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("t1_burst_valid", m_valid, 1);
         checkOutput("t1_burst_data", m_data, vals[i]);
         @(negedge clk);
      end
      checkOutput("t1_word_count", word_count, 4);
      drain();

      $display("[TB] sink stall");
      for (int i = 0; i < 4; i++) pushWord(vals[i]);
      rd0 = rdCount;
      applyStimulus(1'b1, 1'b0);
      repeat (10) nextCycle();
      checkOutput("t2_reads_during_stall", rdCount - rd0, 2);
      checkOutput("t2_valid_held", m_valid, 1);
      checkOutput("t2_data_held", m_data, 8'h11);
      drain();

      $display("[TB] toggling ready");
      for (int i = 1; i <= 8; i++) pushWord(8'(i));
      base = expCount;
      en = 1'b1;
      n = 0;
      while (expQ.size() != 0 && n < 100) begin
         nextCycle();
         m_ready = (n % 2 == 0);
         n++;
      end
      checkOutput("t3_delivered", expCount - base, 8);
      drain();

      $display("[TB] enable dropped on a read cycle");
      pushWord(8'h5A);
      pushWord(8'h5B);
      applyStimulus(1'b1, 1'b1);
      nextCycle();
      checkOutput("t4_read_issue", fifo_rd_enb, 1);
      rd0 = rdCount;
      en = 1'b0;
      repeat (6) nextCycle();
      checkOutput("t4_single_read", rdCount - rd0, 1);
      checkOutput("t4_word_delivered", expQ.size(), 1);
      checkOutput("t4_fifo_left", fifoQ.size(), 1);
      checkOutput("t4_busy_fallen", busy, 0);
      drain();

      $display("[TB] empty fifo then single word");
      applyStimulus(1'b1, 1'b1);
      rd0 = rdCount;
      bad = 0;
      repeat (20) begin
         nextCycle();
         if (m_valid || fifo_rd_enb) bad++;
      end
      checkOutput("t5_no_read_when_empty", rdCount - rd0, 0);
      checkOutput("t5_quiet_when_empty", bad, 0);
      pushWord(8'hA5);
      n = 0;
      @(negedge clk);
      while (!fifo_rd_enb && n < 5) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t5_read_issued", fifo_rd_enb, 1);
      @(negedge clk);
      checkOutput("t5_valid_not_early", m_valid, 0);
      @(negedge clk);
      checkOutput("t5_valid_latency", m_valid, 1);
      checkOutput("t5_data", m_data, 8'hA5);
      drain();

      $display("[TB] reset with buffered words");
      for (int i = 0; i < 4; i++) pushWord(vals[i]);
      rd0 = rdCount;
      applyStimulus(1'b1, 1'b0);
      repeat (6) nextCycle();
      checkOutput("t6_buffered_reads", rdCount - rd0, 2);
      checkOutput("t6_valid_before_reset", m_valid, 1);
      doReset();
      en = 1'b0;
      @(negedge clk);
      checkOutput("t6_m_valid", m_valid, 0);
      checkOutput("t6_word_count", word_count, 0);
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_rd_enb", fifo_rd_enb, 0);
      checkOutput("t6_m_data", m_data, 0);

      $display("[TB] random traffic");
      applyStimulus(1'b1, 1'b1);
      for (int c = 0; c < 3000; c++) begin
         nextCycle();
         if (($urandom % 8) < 3 && fifoQ.size() < 16) pushWord(8'($urandom));
         m_ready = (($urandom % 4) != 0);
         if (($urandom % 32) == 0) en = ~en;
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
